// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and defaults.
package if_fetch_unit_pkg;

    localparam int unsigned PC_W      = 30;
    localparam int unsigned INSN_W    = 32;
    localparam int unsigned TIMEOUT_D = 16;
    localparam int unsigned TW_D      = 5;

    localparam logic [31:0] RESET_PC_D = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_fetch_timer.sv
// Clear/enable cycle counter that flags the last allowed request cycle.
module fetch_timer #(
    parameter int unsigned TW    = 5,
    parameter int unsigned LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    // LIMIT of 0 disables expiry entirely, so LAST is only meaningful otherwise.
    localparam logic [TW-1:0] LAST = (LIMIT == 0) ? '0 : TW'(LIMIT - 1);

    logic [TW-1:0] r_count;

    // Counter: clear has priority over increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign o_expired_c = (LIMIT != 0) && (r_count == LAST);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, IR register and req/ready fetch FSM.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_D,
    parameter int unsigned TIMEOUT  = TIMEOUT_D,
    parameter int unsigned TW       = TW_D
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pc_wr,
    input  logic [PC_W-1:0]   i_npc,
    input  logic              i_fetch_req,
    input  logic              i_fault_clr,
    input  logic              i_imem_ready,
    input  logic [INSN_W-1:0] i_imem_rdata,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    output logic [INSN_W-1:0] o_ir,
    output logic              o_ir_valid,
    output logic              o_fetch_busy,
    output logic              o_fetch_fault
);

    // Byte-offset bits of the reset address are dropped; PC is a word address.
    localparam logic [PC_W-1:0] RESET_WA = RESET_PC[31:2];

    fetch_state_e      r_state;
    logic [PC_W-1:0]   r_pc;
    logic [INSN_W-1:0] r_ir;
    logic              r_imem_req;
    logic              r_ir_valid;
    logic              r_busy;
    logic              r_fault;

    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_tmr_expired;

    // Timer restarts on every entry to S_REQ and counts request cycles without ready.
    assign w_tmr_clr = (r_state == S_IDLE) && i_fetch_req;
    assign w_tmr_en  = (r_state == S_REQ) && !i_imem_ready;

    fetch_timer #(
        .TW    (TW),
        .LIMIT (TIMEOUT)
    ) u_fetch_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_tmr_clr),
        .i_en        (w_tmr_en),
        .o_expired_c (w_tmr_expired)
    );

    // Fetch FSM with PC/IR registers; all status outputs registered alongside state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_WA;
            r_ir       <= '0;
            r_imem_req <= 1'b0;
            r_ir_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_ir_valid <= 1'b0;

            // Address must not move while a request is outstanding.
            if (i_pc_wr && (r_state != S_REQ)) begin
                r_pc <= i_npc;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_fetch_req) begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Ready on the last allowed cycle beats the timeout.
                    if (i_imem_ready) begin
                        r_ir       <= i_imem_rdata;
                        r_state    <= S_DONE;
                        r_imem_req <= 1'b0;
                        r_ir_valid <= 1'b1;
                    end else if (w_tmr_expired) begin
                        r_state    <= S_FAULT;
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_fault    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_FAULT: begin
                    if (i_fault_clr) begin
                        r_state <= S_IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_fault    <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_imem_addr   = r_pc;
    assign o_imem_req    = r_imem_req;
    assign o_ir          = r_ir;
    assign o_ir_valid    = r_ir_valid;
    assign o_fetch_busy  = r_busy;
    assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an expected-IR scoreboard.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wr;
    logic [29:0] npc;
    logic        fetch_req;
    logic        fault_clr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [29:0] pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic [31:0] ir;
    logic        ir_valid;
    logic        fetch_busy;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_ir;
    logic [31:0] last_ir;
    int n;

    if_fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc_wr       (pc_wr),
        .i_npc         (npc),
        .i_fetch_req   (fetch_req),
        .i_fault_clr   (fault_clr),
        .i_imem_ready  (imem_ready),
        .i_imem_rdata  (imem_rdata),
        .o_pc          (pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .o_ir          (ir),
        .o_ir_valid    (ir_valid),
        .o_fetch_busy  (fetch_busy),
        .o_fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for ir_valid; returns cycles taken, or -1 on expiry.
    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (ir_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) chk("ir_valid_timeout", 32'd0, 32'd1);
    endtask

    // Pop the scoreboard and compare against the IR.
    task automatic pop_ir(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            exp_ir = exp_q.pop_front();
            chk(tag, ir, exp_ir);
        end
    endtask

    initial begin
        rst = 1'b1; pc_wr = 1'b0; npc = '0; fetch_req = 1'b0;
        fault_clr = 1'b0; imem_ready = 1'b0; imem_rdata = '0;

        // 1: reset state
        step(); step();
        chk("rst_pc", 32'(pc), 32'h0000_0C00);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        rst = 1'b0;
        step();

        // 2: zero-wait fetch
        fetch_req = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h2408_0005;
        exp_q.push_back(32'h2408_0005);
        step();
        fetch_req = 1'b0;
        chk("zw_req", 32'(imem_req), 32'd1);
        chk("zw_addr", 32'(imem_addr), 32'h0000_0C00);
        chk("zw_busy", 32'(fetch_busy), 32'd1);
        wait_valid(n);
        chk("zw_latency", 32'(n), 32'd1);
        pop_ir("zw_ir");
        chk("zw_req_done", 32'(imem_req), 32'd0);
        step();
        chk("zw_valid_pulse", 32'(ir_valid), 32'd0);
        chk("zw_idle_busy", 32'(fetch_busy), 32'd0);

        // 3: wait states with pc_wr pulsed mid-request
        imem_ready = 1'b0; imem_rdata = 32'h8C09_0004; fetch_req = 1'b1;
        exp_q.push_back(32'h8C09_0004);
        step();
        fetch_req = 1'b0;
        chk("ws_req1", 32'(imem_req), 32'd1);
        chk("ws_addr1", 32'(imem_addr), 32'h0000_0C00);
        pc_wr = 1'b1; npc = 30'h0C01;
        step();
        pc_wr = 1'b0;
        chk("ws_req2", 32'(imem_req), 32'd1);
        chk("ws_pc_held", 32'(pc), 32'h0000_0C00);
        chk("ws_addr2", 32'(imem_addr), 32'h0000_0C00);
        step();
        chk("ws_req3", 32'(imem_req), 32'd1);
        chk("ws_addr3", 32'(imem_addr), 32'h0000_0C00);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("ws_valid", 32'(ir_valid), 32'd1);
        pop_ir("ws_ir");
        chk("ws_pc_done", 32'(pc), 32'h0000_0C00);
        pc_wr = 1'b1; npc = 30'h0C01;
        step();
        pc_wr = 1'b0;
        chk("ws_pc_written", 32'(pc), 32'h0000_0C01);

        // 4: simultaneous pc_wr and fetch_req
        pc_wr = 1'b1; npc = 30'h0C05; fetch_req = 1'b1;
        imem_ready = 1'b1; imem_rdata = 32'hAABB_CCDD;
        exp_q.push_back(32'hAABB_CCDD);
        step();
        pc_wr = 1'b0; fetch_req = 1'b0;
        chk("sim_addr", 32'(imem_addr), 32'h0000_0C05);
        chk("sim_req", 32'(imem_req), 32'd1);
        wait_valid(n);
        pop_ir("sim_ir");
        step();
        last_ir = 32'hAABB_CCDD;

        // 5a: timeout after 16 request cycles
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_fault", 32'(fetch_fault), 32'd1);
        chk("to_req", 32'(imem_req), 32'd0);
        chk("to_ir_kept", ir, last_ir);
        chk("to_busy", 32'(fetch_busy), 32'd0);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("to_req_ignored", 32'(fetch_fault), 32'd1);
        chk("to_req_ignored_req", 32'(imem_req), 32'd0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("to_cleared", 32'(fetch_fault), 32'd0);
        chk("to_cleared_req", 32'(imem_req), 32'd0);

        // 5b: ready exactly on the 16th request cycle
        imem_rdata = 32'h1234_5678; fetch_req = 1'b1;
        exp_q.push_back(32'h1234_5678);
        step();
        fetch_req = 1'b0;
        repeat (15) step();
        chk("edge_req16", 32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("edge_valid", 32'(ir_valid), 32'd1);
        chk("edge_no_fault", 32'(fetch_fault), 32'd0);
        pop_ir("edge_ir");
        step();

        // 6: async reset mid-request
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        chk("ar_req_before", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_pc", 32'(pc), 32'h0000_0C00);
        chk("ar_ir", ir, 32'h0);
        chk("ar_busy", 32'(fetch_busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("ar_idle_req", 32'(imem_req), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
